// File: rtl/my_uart_pkg.sv
// rtl/my_uart_pkg.sv - shared types and constants for the oversampled UART receiver
package my_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int          OSR       = 16;
  localparam int          DATA_W    = 8;
  localparam logic [3:0]  SMP0      = 4'd7;
  localparam logic [3:0]  SMP1      = 4'd8;
  localparam logic [3:0]  SMP2      = 4'd9;
  localparam logic [3:0]  BIT_LAST  = 4'd15;
  localparam logic [2:0]  BCNT_LAST = 3'(DATA_W - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/my_uart_rx_if.sv
// rtl/my_uart_rx_if.sv - serial line plus parallel byte/status bus of the UART receiver
interface my_uart_rx_if;
  import my_uart_pkg::*;

  logic              rs232_rx;
  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic              frame_err;
  logic              rx_busy;

  // master: line driver and byte consumer; slave: the receiver itself
  modport master (
    output rs232_rx,
    input  rx_data,
    input  rx_done,
    input  frame_err,
    input  rx_busy
  );

  modport slave (
    input  rs232_rx,
    output rx_data,
    output rx_done,
    output frame_err,
    output rx_busy
  );

endinterface

// File: rtl/my_uart_tick_gen.sv
// rtl/my_uart_tick_gen.sv - free-running oversample tick divider, one clk pulse every TICK_DIV clocks
module my_uart_tick_gen #(
  parameter int TICK_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // never re-phased to the start edge; start jitter stays within one tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/my_uart_rx.sv
// rtl/my_uart_rx.sv - 8N1 receiver: 2-FF sync, 16x oversampling, 3-sample majority vote
module my_uart_rx
  import my_uart_pkg::*;
#(
  parameter int TICK_DIV = 27
) (
  input  logic        clk,
  input  logic        rst,
  my_uart_rx_if.slave bus
);

  logic tick;

  my_uart_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [1:0] sync_q;
  logic       rx_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.rs232_rx};
    end
  end

  assign rx_sync = sync_q[1];

  rx_state_t         state, state_nx;
  logic [3:0]        scnt, scnt_nx;
  logic [2:0]        bcnt, bcnt_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [1:0]        smp, smp_nx;
  logic [DATA_W-1:0] data_q, data_nx;
  logic              done_q, done_nx;
  logic              err_q, err_nx;
  logic              maj;
  logic              decide;

  // third sample is the live synchronized line at the decision tick
  assign maj    = maj3(smp[0], smp[1], rx_sync);
  assign decide = (scnt == SMP2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      scnt   <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      smp    <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      scnt   <= scnt_nx;
      bcnt   <= bcnt_nx;
      shreg  <= shreg_nx;
      smp    <= smp_nx;
      data_q <= data_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    scnt_nx  = scnt;
    bcnt_nx  = bcnt;
    shreg_nx = shreg;
    smp_nx   = smp;
    data_nx  = data_q;
    done_nx  = 1'b0;
    err_nx   = 1'b0;

    if (tick) begin
      if (state != IDLE) begin
        if (scnt == SMP0) smp_nx[0] = rx_sync;
        if (scnt == SMP1) smp_nx[1] = rx_sync;
      end

      case (state)
        IDLE: begin
          // the detecting tick counts as sample 0 of the start bit
          if (!rx_sync) begin
            state_nx = START;
            scnt_nx  = 4'd1;
          end
        end

        START: begin
          scnt_nx = scnt + 4'd1;
          if (decide && maj) begin
            state_nx = IDLE;
          end else if (scnt == BIT_LAST) begin
            scnt_nx  = 4'd0;
            bcnt_nx  = 3'd0;
            state_nx = DATA;
          end
        end

        DATA: begin
          scnt_nx = scnt + 4'd1;
          if (decide) begin
            shreg_nx = {maj, shreg[DATA_W-1:1]};
          end
          if (scnt == BIT_LAST) begin
            scnt_nx = 4'd0;
            if (bcnt == BCNT_LAST) begin
              state_nx = STOP;
            end else begin
              bcnt_nx = bcnt + 3'd1;
            end
          end
        end

        STOP: begin
          scnt_nx = scnt + 4'd1;
          // leave mid-bit so a start bit right after the stop bit is not missed
          if (decide) begin
            state_nx = IDLE;
            if (maj) begin
              data_nx = shreg;
              done_nx = 1'b1;
            end else begin
              err_nx  = 1'b1;
            end
          end
        end

        default: state_nx = IDLE;
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = err_q;
  assign bus.rx_busy   = (state != IDLE);

endmodule

// File: tb/tb_my_uart_rx.sv
// tb/tb_my_uart_rx.sv - directed self-checking bench for my_uart_rx at TICK_DIV=4
module tb_my_uart_rx;
  import my_uart_pkg::*;

  localparam int TD  = 4;
  localparam int BIT = 64;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  my_uart_rx_if bus ();

  my_uart_rx #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         done_cnt  = 0;
  int         err_cnt   = 0;
  int         busy_run  = 0;
  int         last_busy = 0;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (bus.rx_done) begin
      done_cnt++;
      got.push_back(bus.rx_data);
    end
    if (bus.frame_err) err_cnt++;
    if (bus.rx_busy) begin
      busy_run++;
    end else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) passes++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
  endtask

  function automatic logic [7:0] next_got();
    if (got.size() == 0) return 8'hxx;
    return got.pop_front();
  endfunction

  task automatic drive_bit(input logic v, input int n);
    bus.rs232_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int n, input logic stop_v);
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(b[i], n);
    drive_bit(stop_v, n);
    bus.rs232_rx = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.rs232_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_rx_done", bus.rx_done, 1'b0);
    chk("rst_frame_err", bus.frame_err, 1'b0);
    chk("rst_rx_busy", bus.rx_busy, 1'b0);
    drive_bit(1'b1, BIT);

    // single byte, exact baud; busy spans 153 ticks = 612 clk
    send_byte(8'hA5, BIT, 1'b1);
    drive_bit(1'b1, 3 * BIT);
    chk("a5_done_cnt", done_cnt, 1);
    chk("a5_data", next_got(), 8'hA5);
    chk("a5_err_cnt", err_cnt, 0);
    chk("a5_rx_data", bus.rx_data, 8'hA5);
    chk_range("a5_busy_len", last_busy, 600, 625);

    send_byte(8'h00, BIT, 1'b1);
    send_byte(8'hFF, BIT, 1'b1);
    send_byte(8'h55, BIT, 1'b1);
    drive_bit(1'b1, 3 * BIT);
    chk("b2b_done_cnt", done_cnt, 4);
    chk("b2b_data0", next_got(), 8'h00);
    chk("b2b_data1", next_got(), 8'hFF);
    chk("b2b_data2", next_got(), 8'h55);
    chk("b2b_err_cnt", err_cnt, 0);

    drive_bit(1'b0, 20);
    drive_bit(1'b1, 3 * BIT);
    chk("glitch_done_cnt", done_cnt, 4);
    chk("glitch_err_cnt", err_cnt, 0);
    chk("glitch_busy", bus.rx_busy, 1'b0);
    chk_range("glitch_busy_len", last_busy, 1, 40);

    send_byte(8'h3C, BIT, 1'b0);
    drive_bit(1'b1, 2 * BIT);
    chk("ferr_err_cnt", err_cnt, 1);
    chk("ferr_done_cnt", done_cnt, 4);
    chk("ferr_rx_data_held", bus.rx_data, 8'h55);
    send_byte(8'h81, BIT, 1'b1);
    drive_bit(1'b1, 3 * BIT);
    chk("after_ferr_done_cnt", done_cnt, 5);
    chk("after_ferr_data", next_got(), 8'h81);
    chk("after_ferr_err_cnt", err_cnt, 1);

    send_byte(8'hC3, 66, 1'b1);
    drive_bit(1'b1, 3 * BIT);
    chk("slow3_data", next_got(), 8'hC3);
    send_byte(8'hC3, 62, 1'b1);
    drive_bit(1'b1, 3 * BIT);
    chk("fast3_data", next_got(), 8'hC3);
    chk("baud_done_cnt", done_cnt, 7);
    chk("baud_err_cnt", err_cnt, 1);

    // abort 8'hF0 halfway through data bit 4
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, BIT);
    drive_bit(1'b1, 32);
    chk("abort_busy_before_rst", bus.rx_busy, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_rx_data_rst", bus.rx_data, 8'h00);
    chk("abort_rx_busy_rst", bus.rx_busy, 1'b0);
    chk("abort_rx_done_rst", bus.rx_done, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive_bit(1'b1, 2 * BIT);
    chk("abort_done_cnt", done_cnt, 7);
    chk("abort_err_cnt", err_cnt, 1);
    chk("abort_idle_busy", bus.rx_busy, 1'b0);
    send_byte(8'h0F, BIT, 1'b1);
    drive_bit(1'b1, 3 * BIT);
    chk("post_rst_done_cnt", done_cnt, 8);
    chk("post_rst_data", next_got(), 8'h0F);
    chk("post_rst_rx_data", bus.rx_data, 8'h0F);
    chk("post_rst_err_cnt", err_cnt, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
